// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three result sources (alu0, alu1, ls), each with a
// one-entry holding buffer, round-robin granted onto a registered broadcast bus.
// Optional feature: define CDB_BYPASS_EN to let a source with an empty buffer
// compete with its live input and be broadcast in the same cycle it is offered.
module cdb_arbiter #(
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               flush_in,
    input  logic               alu0_valid_in,
    input  logic               alu1_valid_in,
    input  logic               ls_valid_in,
    input  logic [TAG_W-1:0]   alu0_tag_in,
    input  logic [TAG_W-1:0]   alu1_tag_in,
    input  logic [TAG_W-1:0]   ls_tag_in,
    input  logic [RADDR_W-1:0] alu0_addr_in,
    input  logic [RADDR_W-1:0] alu1_addr_in,
    input  logic [RADDR_W-1:0] ls_addr_in,
    input  logic [DATA_W-1:0]  alu0_data_in,
    input  logic [DATA_W-1:0]  alu1_data_in,
    input  logic [DATA_W-1:0]  ls_data_in,
    output logic               alu0_ready_out,
    output logic               alu1_ready_out,
    output logic               ls_ready_out,
    output logic               cdb_en_out,
    output logic [TAG_W-1:0]   cdb_tag_out,
    output logic [RADDR_W-1:0] cdb_addr_out,
    output logic [DATA_W-1:0]  cdb_data_out,
    output logic [1:0]         cdb_src_out
);

    localparam int unsigned N_SRC = 3;

    logic [N_SRC-1:0]   in_valid;
    logic [TAG_W-1:0]   in_tag  [N_SRC];
    logic [RADDR_W-1:0] in_addr [N_SRC];
    logic [DATA_W-1:0]  in_data [N_SRC];

    logic [N_SRC-1:0]   occ;
    logic [TAG_W-1:0]   buf_tag  [N_SRC];
    logic [RADDR_W-1:0] buf_addr [N_SRC];
    logic [DATA_W-1:0]  buf_data [N_SRC];
    logic [1:0]         rr_ptr;

    logic [N_SRC-1:0]   cand;
    logic [N_SRC-1:0]   gnt_oh;
    logic [N_SRC-1:0]   bypass_win;
    logic [N_SRC-1:0]   ready;
    logic               gnt_any;
    logic [1:0]         gnt_idx;
    logic [2:0]         pos;
    logic [TAG_W-1:0]   w_tag;
    logic [RADDR_W-1:0] w_addr;
    logic [DATA_W-1:0]  w_data;

    // Gather the per-source ports into indexed arrays (0=alu0, 1=alu1, 2=ls)
    assign in_valid   = {ls_valid_in, alu1_valid_in, alu0_valid_in};
    assign in_tag[0]  = alu0_tag_in;
    assign in_tag[1]  = alu1_tag_in;
    assign in_tag[2]  = ls_tag_in;
    assign in_addr[0] = alu0_addr_in;
    assign in_addr[1] = alu1_addr_in;
    assign in_addr[2] = ls_addr_in;
    assign in_data[0] = alu0_data_in;
    assign in_data[1] = alu1_data_in;
    assign in_data[2] = ls_data_in;

`ifdef CDB_BYPASS_EN
    assign cand = occ | in_valid;
`else
    assign cand = occ;
`endif

    // Round-robin search starting at rr_ptr, wrapping modulo 3
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        pos     = 3'd0;
        for (int k = 0; k < int'(N_SRC); k++) begin
            pos = 3'(rr_ptr) + 3'(k);
            if (pos >= 3'd3) pos = pos - 3'd3;
            for (int j = 0; j < int'(N_SRC); j++) begin
                if (!gnt_any && pos[1:0] == 2'(j) && cand[j]) begin
                    gnt_any = 1'b1;
                    gnt_idx = 2'(j);
                end
            end
        end
    end

    // Winner payload: buffered entry if occupied, otherwise the live bypass input
    always_comb begin
        w_tag      = '0;
        w_addr     = '0;
        w_data     = '0;
        gnt_oh     = '0;
        bypass_win = '0;
        ready      = '0;
        for (int j = 0; j < int'(N_SRC); j++) begin
            gnt_oh[j]     = gnt_any && (gnt_idx == 2'(j));
            bypass_win[j] = gnt_oh[j] && !occ[j];
            ready[j]      = rst && rdy && !flush_in && (!occ[j] || gnt_oh[j]);
            if (gnt_oh[j]) begin
                w_tag  = occ[j] ? buf_tag[j]  : in_tag[j];
                w_addr = occ[j] ? buf_addr[j] : in_addr[j];
                w_data = occ[j] ? buf_data[j] : in_data[j];
            end
        end
    end

    assign alu0_ready_out = ready[0];
    assign alu1_ready_out = ready[1];
    assign ls_ready_out   = ready[2];

    // Holding buffers, round-robin pointer and registered broadcast bus
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ          <= '0;
            rr_ptr       <= 2'd0;
            cdb_en_out   <= 1'b0;
            cdb_tag_out  <= '0;
            cdb_addr_out <= '0;
            cdb_data_out <= '0;
            cdb_src_out  <= 2'd0;
            for (int j = 0; j < int'(N_SRC); j++) begin
                buf_tag[j]  <= '0;
                buf_addr[j] <= '0;
                buf_data[j] <= '0;
            end
        end else if (rdy) begin
            if (flush_in) begin
                occ        <= '0;
                cdb_en_out <= 1'b0;
            end else begin
                cdb_en_out <= gnt_any;
                if (gnt_any) begin
                    cdb_tag_out  <= w_tag;
                    cdb_addr_out <= w_addr;
                    cdb_data_out <= w_data;
                    cdb_src_out  <= gnt_idx;
                    rr_ptr       <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
                end
                for (int j = 0; j < int'(N_SRC); j++) begin
                    if (in_valid[j] && ready[j] && !bypass_win[j]) begin
                        occ[j]      <= 1'b1;
                        buf_tag[j]  <= in_tag[j];
                        buf_addr[j] <= in_addr[j];
                        buf_data[j] <= in_data[j];
                    end else if (gnt_oh[j]) begin
                        occ[j] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default build, no bypass).
module tb_cdb_arbiter;

    localparam int unsigned TAG_W   = 4;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned DATA_W  = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               rdy = 1'b1;
    logic               flush_in = 1'b0;
    logic               alu0_valid_in = 1'b0, alu1_valid_in = 1'b0, ls_valid_in = 1'b0;
    logic [TAG_W-1:0]   alu0_tag_in = '0, alu1_tag_in = '0, ls_tag_in = '0;
    logic [RADDR_W-1:0] alu0_addr_in = '0, alu1_addr_in = '0, ls_addr_in = '0;
    logic [DATA_W-1:0]  alu0_data_in = '0, alu1_data_in = '0, ls_data_in = '0;
    logic               alu0_ready_out, alu1_ready_out, ls_ready_out;
    logic               cdb_en_out;
    logic [TAG_W-1:0]   cdb_tag_out;
    logic [RADDR_W-1:0] cdb_addr_out;
    logic [DATA_W-1:0]  cdb_data_out;
    logic [1:0]         cdb_src_out;
    logic [2:0]         rdy_v;

    int n_checks = 0;
    int n_fail   = 0;

    cdb_arbiter #(.TAG_W(TAG_W), .RADDR_W(RADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush_in(flush_in),
        .alu0_valid_in(alu0_valid_in), .alu1_valid_in(alu1_valid_in), .ls_valid_in(ls_valid_in),
        .alu0_tag_in(alu0_tag_in), .alu1_tag_in(alu1_tag_in), .ls_tag_in(ls_tag_in),
        .alu0_addr_in(alu0_addr_in), .alu1_addr_in(alu1_addr_in), .ls_addr_in(ls_addr_in),
        .alu0_data_in(alu0_data_in), .alu1_data_in(alu1_data_in), .ls_data_in(ls_data_in),
        .alu0_ready_out(alu0_ready_out), .alu1_ready_out(alu1_ready_out), .ls_ready_out(ls_ready_out),
        .cdb_en_out(cdb_en_out), .cdb_tag_out(cdb_tag_out), .cdb_addr_out(cdb_addr_out),
        .cdb_data_out(cdb_data_out), .cdb_src_out(cdb_src_out)
    );

    always #5 clk = ~clk;
    assign rdy_v = {ls_ready_out, alu1_ready_out, alu0_ready_out};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [TAG_W-1:0] t,
                         input logic [RADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        case (i)
            0: begin alu0_valid_in = v; alu0_tag_in = t; alu0_addr_in = a; alu0_data_in = d; end
            1: begin alu1_valid_in = v; alu1_tag_in = t; alu1_addr_in = a; alu1_data_in = d; end
            default: begin ls_valid_in = v; ls_tag_in = t; ls_addr_in = a; ls_data_in = d; end
        endcase
    endtask

    task automatic idle_all();
        alu0_valid_in = 1'b0;
        alu1_valid_in = 1'b0;
        ls_valid_in   = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        rdy = 1'b1;
        flush_in = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({cdb_en_out, cdb_src_out, cdb_tag_out, cdb_addr_out, cdb_data_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b src=%0d tag=%0d addr=%0d data=%h, want all 0",
                     cdb_en_out, cdb_src_out, cdb_tag_out, cdb_addr_out, cdb_data_out);
        end
        n_checks++;
        if (rdy_v !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ready_low: got %b want 000", rdy_v);
        end
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({cdb_en_out, rdy_v} !== 4'b0111) begin
            n_fail++;
            $display("FAIL reset_release: got en=%b ready=%b want en=0 ready=111", cdb_en_out, rdy_v);
        end
    endtask

    task automatic test_single();
        drive(0, 1'b1, 4'd3, 5'd5, 32'hDEADBEEF);
        tick();
        idle_all();
        n_checks++;
        if (cdb_en_out !== 1'b0) begin
            n_fail++;
            $display("FAIL single_not_early: got en=%b want 0", cdb_en_out);
        end
        tick();
        n_checks++;
        if ({cdb_en_out, cdb_src_out, cdb_tag_out, cdb_addr_out, cdb_data_out} !==
            {1'b1, 2'd0, 4'd3, 5'd5, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL single_bcast: got en=%b src=%0d tag=%0d addr=%0d data=%h want 1/0/3/5/deadbeef",
                     cdb_en_out, cdb_src_out, cdb_tag_out, cdb_addr_out, cdb_data_out);
        end
        tick();
        n_checks++;
        if ({cdb_en_out, cdb_src_out, cdb_tag_out} !== {1'b0, 2'd0, 4'd3}) begin
            n_fail++;
            $display("FAIL single_hold: got en=%b src=%0d tag=%0d want 0/0/3",
                     cdb_en_out, cdb_src_out, cdb_tag_out);
        end
    endtask

    task automatic test_collision();
        logic [6:0]  exp_bus [4];
        logic [2:0]  exp_rdy [4];
        do_reset();
        exp_bus[0] = {1'b1, 2'd0, 4'd1};  exp_rdy[0] = 3'b011;
        exp_bus[1] = {1'b1, 2'd1, 4'd0};  exp_rdy[1] = 3'b111;
        exp_bus[2] = {1'b1, 2'd2, 4'd10}; exp_rdy[2] = 3'b111;
        exp_bus[3] = {1'b0, 2'd2, 4'd10}; exp_rdy[3] = 3'b111;
        drive(0, 1'b1, 4'd1, 5'd1, 32'h100);
        drive(1, 1'b1, 4'd0, 5'd2, 32'h200);
        drive(2, 1'b1, 4'd10, 5'd3, 32'h300);
        tick();
        idle_all();
        n_checks++;
        if (rdy_v !== 3'b001) begin
            n_fail++;
            $display("FAIL coll_ready_full: got %b want 001", rdy_v);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if ({cdb_en_out, cdb_src_out, cdb_tag_out} !== exp_bus[c] || rdy_v !== exp_rdy[c]) begin
                n_fail++;
                $display("FAIL coll_step%0d: got bus=%h ready=%b want bus=%h ready=%b",
                         c, {cdb_en_out, cdb_src_out, cdb_tag_out}, rdy_v, exp_bus[c], exp_rdy[c]);
            end
        end
        drive(1, 1'b1, 4'd5, 5'd7, 32'h55);
        drive(2, 1'b1, 4'd6, 5'd8, 32'h66);
        tick();
        idle_all();
        tick();
        n_checks++;
        if ({cdb_en_out, cdb_src_out, cdb_tag_out} !== {1'b1, 2'd1, 4'd5}) begin
            n_fail++;
            $display("FAIL coll_ptr_wrapped: got en=%b src=%0d tag=%0d want 1/1/5",
                     cdb_en_out, cdb_src_out, cdb_tag_out);
        end
        tick();
        n_checks++;
        if ({cdb_en_out, cdb_src_out, cdb_tag_out} !== {1'b1, 2'd2, 4'd6}) begin
            n_fail++;
            $display("FAIL coll_ptr_next: got en=%b src=%0d tag=%0d want 1/2/6",
                     cdb_en_out, cdb_src_out, cdb_tag_out);
        end
    endtask

    task automatic test_fairness();
        int low0 = 0, low2 = 0, max0 = 0, max2 = 0;
        logic [1:0]       esrc;
        logic [DATA_W-1:0] edata;
        do_reset();
        drive(0, 1'b1, 4'd4, 5'd1, 32'hA0);
        drive(2, 1'b1, 4'd12, 5'd2, 32'hB2);
        for (int c = 1; c <= 10; c++) begin
            tick();
            esrc  = (c % 2 == 0) ? 2'd0 : 2'd2;
            edata = (c % 2 == 0) ? 32'hA0 : 32'hB2;
            n_checks++;
            if (c == 1) begin
                if (cdb_en_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fair_first: got en=%b want 0", cdb_en_out);
                end
            end else if ({cdb_en_out, cdb_src_out, cdb_data_out} !== {1'b1, esrc, edata}) begin
                n_fail++;
                $display("FAIL fair_c%0d: got en=%b src=%0d data=%h want 1/%0d/%h",
                         c, cdb_en_out, cdb_src_out, cdb_data_out, esrc, edata);
            end
            low0 = alu0_ready_out ? 0 : low0 + 1;
            low2 = ls_ready_out   ? 0 : low2 + 1;
            if (low0 > max0) max0 = low0;
            if (low2 > max2) max2 = low2;
        end
        n_checks++;
        if (max0 > 1 || max2 > 1) begin
            n_fail++;
            $display("FAIL fair_ready_run: got max low run alu0=%0d ls=%0d want <=1", max0, max2);
        end
        idle_all();
        tick();
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        drive(0, 1'b1, 4'd7, 5'd1, 32'h7);
        drive(1, 1'b1, 4'd8, 5'd2, 32'h8);
        drive(2, 1'b1, 4'd9, 5'd3, 32'h9);
        tick();
        idle_all();
        flush_in = 1'b1;
        #1;
        n_checks++;
        if (rdy_v !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_ready_low: got %b want 000", rdy_v);
        end
        tick();
        flush_in = 1'b0;
        #1;
        n_checks++;
        if ({cdb_en_out, rdy_v} !== 4'b0111) begin
            n_fail++;
            $display("FAIL flush_after: got en=%b ready=%b want en=0 ready=111", cdb_en_out, rdy_v);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (cdb_en_out !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_stale%0d: got en=%b tag=%0d want en=0", c, cdb_en_out, cdb_tag_out);
            end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        drive(0, 1'b1, 4'd2, 5'd4, 32'h1111);
        tick();
        drive(0, 1'b0, 4'd0, 5'd0, 32'h0);
        drive(1, 1'b1, 4'd6, 5'd9, 32'h6666);
        tick();
        idle_all();
        rdy = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (rdy_v !== 3'b000) begin
                n_fail++;
                $display("FAIL freeze_ready%0d: got %b want 000", c, rdy_v);
            end
            tick();
            n_checks++;
            if ({cdb_en_out, cdb_src_out, cdb_tag_out} !== {1'b1, 2'd0, 4'd2}) begin
                n_fail++;
                $display("FAIL freeze_hold%0d: got en=%b src=%0d tag=%0d want 1/0/2",
                         c, cdb_en_out, cdb_src_out, cdb_tag_out);
            end
        end
        rdy = 1'b1;
        tick();
        n_checks++;
        if ({cdb_en_out, cdb_src_out, cdb_tag_out, cdb_addr_out, cdb_data_out} !==
            {1'b1, 2'd1, 4'd6, 5'd9, 32'h6666}) begin
            n_fail++;
            $display("FAIL freeze_resume: got en=%b src=%0d tag=%0d addr=%0d data=%h want 1/1/6/9/6666",
                     cdb_en_out, cdb_src_out, cdb_tag_out, cdb_addr_out, cdb_data_out);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 1'b1, 4'd1, 5'd1, 32'h1);
        drive(1, 1'b1, 4'd2, 5'd2, 32'h2);
        drive(2, 1'b1, 4'd3, 5'd3, 32'h3);
        tick();
        idle_all();
        tick();
        tick();
        n_checks++;
        if ({cdb_en_out, cdb_src_out, cdb_tag_out} !== {1'b1, 2'd1, 4'd2}) begin
            n_fail++;
            $display("FAIL rmid_pre: got en=%b src=%0d tag=%0d want 1/1/2",
                     cdb_en_out, cdb_src_out, cdb_tag_out);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({cdb_en_out, cdb_src_out, cdb_tag_out, rdy_v} !== 10'd0) begin
            n_fail++;
            $display("FAIL rmid_async: got en=%b src=%0d tag=%0d ready=%b want all 0",
                     cdb_en_out, cdb_src_out, cdb_tag_out, rdy_v);
        end
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (rdy_v !== 3'b111) begin
            n_fail++;
            $display("FAIL rmid_ready: got %b want 111", rdy_v);
        end
        tick();
        n_checks++;
        if (cdb_en_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_empty: got en=%b want 0", cdb_en_out);
        end
        drive(1, 1'b1, 4'd11, 5'd1, 32'hB);
        drive(2, 1'b1, 4'd12, 5'd2, 32'hC);
        tick();
        idle_all();
        tick();
        n_checks++;
        if ({cdb_en_out, cdb_src_out, cdb_tag_out} !== {1'b1, 2'd1, 4'd11}) begin
            n_fail++;
            $display("FAIL rmid_ptr0: got en=%b src=%0d tag=%0d want 1/1/11",
                     cdb_en_out, cdb_src_out, cdb_tag_out);
        end
        tick();
        n_checks++;
        if ({cdb_en_out, cdb_src_out, cdb_tag_out} !== {1'b1, 2'd2, 4'd12}) begin
            n_fail++;
            $display("FAIL rmid_next: got en=%b src=%0d tag=%0d want 1/2/12",
                     cdb_en_out, cdb_src_out, cdb_tag_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_collision();
        test_fairness();
        test_flush();
        test_freeze();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL take parameters, one per line: name, default, meaning.
- TAG_W, 4, register-tag width; tag value 0 means UNLOCKED.
- RADDR_W, 5, register-address width.
- DATA_W, 32, result-word width.
REQ-002 SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- rdy, in, 1, global enable; 0 freezes the block.
- flush_in, in, 1, mispredict flush.
- alu0_valid_in / alu1_valid_in / ls_valid_in, in, 1 each, result offered by that unit.
- alu0_tag_in / alu1_tag_in / ls_tag_in, in, TAG_W each, tag of the result.
- alu0_addr_in / alu1_addr_in / ls_addr_in, in, RADDR_W each, destination register.
- alu0_data_in / alu1_data_in / ls_data_in, in, DATA_W each, result value.
- alu0_ready_out / alu1_ready_out / ls_ready_out, out, 1 each, source accepted this cycle.
- cdb_en_out, out, 1, broadcast valid.
- cdb_tag_out, out, TAG_W, broadcast tag.
- cdb_addr_out, out, RADDR_W, broadcast register address.
- cdb_data_out, out, DATA_W, broadcast data.
- cdb_src_out, out, 2, winner: 0=alu0, 1=alu1, 2=ls.

Function
REQ-003 SHALL give each source (index 0=alu0, 1=alu1, 2=ls) a one-entry holding buffer {occ, tag, addr, data}.
REQ-004 SHALL capture a source's input into its buffer at a rising edge when valid_in=1 and ready_out=1 (handshake).
REQ-005 SHALL drive ready_out combinationally as rdy & ~flush_in & (~occ | granted-this-cycle), with no path from valid_in.
REQ-006 SHALL choose the grant combinationally each cycle from the candidates (occupied buffers) by round-robin, starting at rr_ptr and searching upward modulo 3.
REQ-007 SHALL, at each edge with rdy=1, flush_in=0 and at least one candidate:
- register the winner's tag, addr and data onto cdb_*_out;
- set cdb_en_out=1 and cdb_src_out to the winner index;
- clear the winner's occ;
- set rr_ptr to (winner+1) mod 3.
REQ-008 SHALL register cdb_en_out=0 at an edge with no candidate, holding cdb_tag/addr/data/src at their last values.
REQ-009 SHALL allow the granted buffer to be freed and reloaded by the same source at the same edge, so one source can sustain one result per cycle when uncontended.
REQ-010 SHALL leave rr_ptr unchanged when there is no grant; rr_ptr SHALL only take values 0, 1, 2.
REQ-011 SHALL give the minimum latency, without bypass, as: input accepted at edge k, broadcast visible after edge k+1.
REQ-012 SHALL, when flush_in=1 at an edge with rdy=1, clear all occ and set cdb_en_out=0; no capture and no grant take place at that edge; rr_ptr holds.
REQ-013 SHALL, when rdy=0, hold all state including cdb_*_out and rr_ptr, and drive all ready_out=0.
REQ-014 SHALL treat a result whose tag equals 0 like any other result; it is buffered and broadcast.

Reset
REQ-015 SHALL, while rst=0 and independent of clk, clear:
- all occ flags;
- rr_ptr to 0;
- cdb_en_out, cdb_tag_out, cdb_addr_out, cdb_data_out and cdb_src_out to 0.
REQ-016 SHALL drive all ready_out=0 while rst=0, and resume normal operation from the first rising edge after rst returns to 1.

Configuration
REQ-017 SHALL support the macro CDB_BYPASS_EN.
- Defined: the candidates also include valid_in of each source whose buffer is empty. A bypass winner is broadcast directly at edge k and never written to its buffer. A bypass loser is captured per REQ-004.
- Undefined: the candidates are the occupied buffers only, giving the 2-edge latency of REQ-011.

Verification
REQ-018 SHALL cover reset: assert rst=0 mid-stream with all buffers full -> cdb_en_out=0 and cdb_src_out=0 immediately (before the next clk edge); after release, all ready_out=1 and rr_ptr=0.
REQ-019 SHALL cover a single result: alu0 offers tag=3, addr=5, data=0xDEADBEEF at edge k -> cdb_en_out=1, tag 3, addr 5, data 0xDEADBEEF, src 0 after edge k+1; with CDB_BYPASS_EN, after edge k.
REQ-020 SHALL cover a three-way collision: all three sources valid for one cycle from reset -> broadcasts src 0, 1, 2 on three consecutive edges, then cdb_en_out=0 and rr_ptr=0.
REQ-021 SHALL cover fairness: alu0 and ls valid every cycle for 10 cycles -> srcs alternate 0, 2, 0, 2...; neither ready_out stays low for more than 1 consecutive cycle.
REQ-022 SHALL cover flush: flush_in=1 for one edge with all three buffers full -> cdb_en_out=0 after that edge, all ready_out=1 next cycle, and no stale tag is ever broadcast.
REQ-023 SHALL cover a freeze: rdy=0 for 3 cycles with alu1 pending -> cdb outputs frozen, all ready_out=0; the alu1 result is broadcast on the first edge after rdy=1.
